mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction and data request paths of the pipelined MIPS core. It shares one RAM port between the two paths and gives data priority, with a bounded-starvation guarantee for instruction fetch. It also holds the LL/SC reservation (link register) and resolves SC success or failure before any RAM write. It sits between the caches' memory-side ports and the RAM model and drives the `iwait`/`dwait` stalls that become `ihit`/`dhit` upstream.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the MIPS core's instruction and data paths.
// Data has priority and instruction fetch cannot starve. It also holds the LL/SC link register.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        datomic,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int          SCNT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERV  = 2'd1,
        ISERV  = 2'd2,
        SCFAIL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                link_valid_q, link_valid_d;
    logic [29:0]         link_addr_q, link_addr_d;
    // The data operation kind is captured at grant so a withdrawn request still finishes at the RAM.
    logic                op_we_q, op_we_d;
    logic                op_re_q, op_re_d;
    logic                op_atomic_q, op_atomic_d;

    logic d_req;
    logic sc_req;
    logic link_hit;

    assign d_req    = dREN | dWEN;
    assign sc_req   = dWEN & datomic;
    assign link_hit = link_valid_q && (daddr[31:2] == link_addr_q);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        scnt_d       = scnt_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        op_we_d      = op_we_q;
        op_re_d      = op_re_q;
        op_atomic_d  = op_atomic_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        unique case (state_q)
            IDLE: begin
                if (!iREN) scnt_d = '0;
                if (sc_req && !link_hit) begin
                    state_d = SCFAIL;
                end else if (d_req && ((scnt_q < SCNT_W'(STARVE_MAX)) || !iREN)) begin
                    state_d     = DSERV;
                    op_we_d     = dWEN;
                    op_re_d     = dREN & ~dWEN;
                    op_atomic_d = datomic;
                end else if (iREN) begin
                    state_d = ISERV;
                end
            end

            DSERV: begin
                ramaddr  = daddr;
                ramWEN   = op_we_q;
                ramREN   = op_re_q;
                ramstore = dstore;
                if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    dload   = (op_we_q && op_atomic_q) ? 32'h1 : ramload;
                    state_d = IDLE;
                    if (iREN && (scnt_q != SCNT_W'(STARVE_MAX))) scnt_d = scnt_q + SCNT_W'(1);
                    if (op_atomic_q) begin
                        if (op_we_q) begin
                            link_valid_d = 1'b0;
                        end else begin
                            link_valid_d = 1'b1;
                            link_addr_d  = daddr[31:2];
                        end
                    end else if (op_we_q && (daddr[31:2] == link_addr_q)) begin
                        link_valid_d = 1'b0;
                    end
                end
            end

            ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramstate == RAM_ACCESS) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    scnt_d  = '0;
                    state_d = IDLE;
                end
            end

            SCFAIL: begin
                dwait        = 1'b0;
                dload        = '0;
                link_valid_d = 1'b0;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            scnt_q       <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            op_we_q      <= 1'b0;
            op_re_q      <= 1'b0;
            op_atomic_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in step with the clock edge.
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            op_we_q      <= op_we_d;
            op_re_q      <= op_re_d;
            op_atomic_q  <= op_atomic_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, starvation bound, LL/SC, RAM stalls, reset abort.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN, dWEN, datomic;
    logic [31:0] daddr, dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_req;
        iREN    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        datomic = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; clear_req();
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        @(negedge CLK); #1;
        n_cmp++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 1100", {iwait, dwait, ramREN, ramWEN});
        end
        n_cmp++;
        if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {iload, dload, ramaddr, ramstore});
        end
        @(negedge CLK); nRST = 1'b1;
        tick();
    endtask

    task automatic test_ifetch;
        iREN = 1'b1; iaddr = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({ramREN, iwait} !== 2'b01) begin
            n_bad++; $display("FAIL ifetch_idle: got ramREN,iwait=%b want 01", {ramREN, iwait});
        end
        tick(); #1;
        n_cmp++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b1001) begin
            n_bad++; $display("FAIL ifetch_strobes: got %b want 1001", {ramREN, ramWEN, iwait, dwait});
        end
        n_cmp++;
        if (ramaddr !== 32'h100) begin
            n_bad++; $display("FAIL ifetch_addr: got %h want 00000100", ramaddr);
        end
        n_cmp++;
        if (iload !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL ifetch_load: got %h want deadbeef", iload);
        end
        clear_req();
        tick(); #1;
        n_cmp++;
        if ({iwait, ramREN} !== 2'b10) begin
            n_bad++; $display("FAIL ifetch_back_idle: got %b want 10", {iwait, ramREN});
        end
    endtask

    // Data grants on odd cycles until four have been given, then one fetch; the pattern repeats.
    task automatic test_starvation;
        logic [1:0] exp_wait;
        iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h400;
        ramstate = ACCESS; ramload = 32'h0000_5555;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_wait = 2'b11;
            if (c == 1 || c == 3 || c == 5 || c == 7 || c == 11 || c == 13 || c == 15 || c == 17)
                exp_wait = 2'b10;
            if (c == 9 || c == 19)
                exp_wait = 2'b01;
            n_cmp++;
            if ({iwait, dwait} !== exp_wait) begin
                n_bad++; $display("FAIL starve_c%0d: got iwait,dwait=%b want %b", c, {iwait, dwait}, exp_wait);
            end
            if (c == 1) begin
                n_cmp++;
                if ({ramREN, ramaddr} !== {1'b1, 32'h400}) begin
                    n_bad++; $display("FAIL starve_daddr: got %b/%h want 1/00000400", ramREN, ramaddr);
                end
            end
            tick();
        end
        clear_req();
        tick();
    endtask

    task automatic test_llsc;
        // LL to 0x40
        dREN = 1'b1; datomic = 1'b1; daddr = 32'h40; ramstate = ACCESS; ramload = 32'h1234;
        tick(); #1;
        n_cmp++;
        if ({dwait, ramREN, ramWEN, dload} !== {3'b010, 32'h1234}) begin
            n_bad++; $display("FAIL ll1: got dwait,ren,wen=%b dload=%h want 010/00001234", {dwait, ramREN, ramWEN}, dload);
        end
        clear_req(); tick();
        // SC to 0x44 misses the link
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h44; dstore = 32'h7;
        tick(); #1;
        n_cmp++;
        if ({dwait, ramREN, ramWEN, dload} !== {3'b000, 32'h0}) begin
            n_bad++; $display("FAIL sc_miss: got dwait,ren,wen=%b dload=%h want 000/0", {dwait, ramREN, ramWEN}, dload);
        end
        clear_req(); tick();
        // fresh LL then matching SC
        dREN = 1'b1; datomic = 1'b1; daddr = 32'h40;
        tick(); clear_req(); tick();
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h40; dstore = 32'h7;
        tick(); #1;
        n_cmp++;
        if ({dwait, ramREN, ramWEN, dload} !== {3'b001, 32'h1}) begin
            n_bad++; $display("FAIL sc_hit: got dwait,ren,wen=%b dload=%h want 001/1", {dwait, ramREN, ramWEN}, dload);
        end
        n_cmp++;
        if ({ramaddr, ramstore} !== {32'h40, 32'h7}) begin
            n_bad++; $display("FAIL sc_hit_bus: got %h/%h want 00000040/00000007", ramaddr, ramstore);
        end
        clear_req(); tick();
        // the successful SC consumed the link
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h40;
        tick(); #1;
        n_cmp++;
        if ({dwait, ramWEN, dload} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL sc_after_sc: got dwait,wen=%b dload=%h want 00/0", {dwait, ramWEN}, dload);
        end
        clear_req(); tick();
    endtask

    task automatic test_store_kills_link;
        // LL 0x80, SW 0x84 (different word), SC 0x80 still succeeds
        dREN = 1'b1; datomic = 1'b1; daddr = 32'h80; ramstate = ACCESS;
        tick(); clear_req(); tick();
        dWEN = 1'b1; daddr = 32'h84; dstore = 32'h5;
        tick(); clear_req(); tick();
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h80; dstore = 32'h9;
        tick(); #1;
        n_cmp++;
        if ({ramWEN, dload} !== {1'b1, 32'h1}) begin
            n_bad++; $display("FAIL sc_other_sw: got wen=%b dload=%h want 1/1", ramWEN, dload);
        end
        clear_req(); tick();
        // LL 0x80, SW 0x80, SC 0x80 fails
        dREN = 1'b1; datomic = 1'b1; daddr = 32'h80;
        tick(); clear_req(); tick();
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h5;
        tick(); #1;
        n_cmp++;
        if ({dwait, ramWEN} !== 2'b01) begin
            n_bad++; $display("FAIL sw_write: got dwait,wen=%b want 01", {dwait, ramWEN});
        end
        clear_req(); tick();
        dWEN = 1'b1; datomic = 1'b1; daddr = 32'h80;
        tick(); #1;
        n_cmp++;
        if ({dwait, ramWEN, dload} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL sc_after_sw: got dwait,wen=%b dload=%h want 00/0", {dwait, ramWEN}, dload);
        end
        clear_req(); tick();
    endtask

    task automatic test_ram_stall;
        logic [1:0] rs [5];
        rs[0] = BUSY; rs[1] = BUSY; rs[2] = BUSY; rs[3] = ERROR; rs[4] = ACCESS;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hA5A5; ramstate = BUSY;
        for (int c = 0; c < 5; c++) begin
            tick();
            ramstate = rs[c];
            #1;
            n_cmp++;
            if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'hA5A5}) begin
                n_bad++; $display("FAIL stall_bus_c%0d: got wen,ren=%b %h/%h want 10 00000200/0000a5a5", c, {ramWEN, ramREN}, ramaddr, ramstore);
            end
            n_cmp++;
            if (dwait !== (c < 4)) begin
                n_bad++; $display("FAIL stall_dwait_c%0d: got %b want %b", c, dwait, (c < 4));
            end
            if (c == 3) clear_req();
        end
        tick(); #1;
        n_cmp++;
        if ({dwait, ramWEN} !== 2'b10) begin
            n_bad++; $display("FAIL stall_done: got dwait,wen=%b want 10", {dwait, ramWEN});
        end
    endtask

    task automatic test_reset_abort;
        iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY; ramload = 32'hCAFE0001;
        tick(); #1;
        n_cmp++;
        if ({ramREN, iwait, ramaddr} !== {2'b11, 32'h300}) begin
            n_bad++; $display("FAIL abort_pre: got ren,iwait=%b addr=%h want 11/00000300", {ramREN, iwait}, ramaddr);
        end
        #1 nRST = 1'b0;
        #1;
        n_cmp++;
        if ({ramREN, iwait, ramaddr} !== {2'b01, 32'h0}) begin
            n_bad++; $display("FAIL abort_async: got ren,iwait=%b addr=%h want 01/0", {ramREN, iwait}, ramaddr);
        end
        @(negedge CLK);
        nRST = 1'b1; ramstate = ACCESS;
        #1;
        n_cmp++;
        if ({ramREN, iwait} !== 2'b01) begin
            n_bad++; $display("FAIL abort_idle: got ren,iwait=%b want 01", {ramREN, iwait});
        end
        tick(); #1;
        n_cmp++;
        if ({ramREN, iwait, iload} !== {2'b10, 32'hCAFE0001}) begin
            n_bad++; $display("FAIL abort_regrant: got ren,iwait=%b iload=%h want 10/cafe0001", {ramREN, iwait}, iload);
        end
        clear_req(); tick();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_starvation();
        test_llsc();
        test_store_kills_link();
        test_ram_stall();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
